// File: rtl/program_load_ctrl.sv
// program_load_ctrl: parses a framed SPART byte stream into program memory, then hands the port to the CPU
// Ports: clk, rst (async, active-high); rx_data/rx_valid byte stream in; reload restarts loading;
// cpu_addr/cpu_en CPU fetch request; mem_addr/mem_data_in/mem_enable/mem_wr program memory port;
// cpu_hold, load_done, load_err status levels; words_loaded words written in the current/last frame.
module program_load_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] DEPTH     = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        reload,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
    } state_t;
    state_t      state;
    logic [7:0]  xacc;
    logic [7:0]  hi;
    logic [15:0] cnt;
    logic [15:0] waddr;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_wr;
    logic [15:0] len;
    assign len = {hi, rx_data};
    // CPU owns the port combinationally once the load has been verified
    assign mem_addr    = cpu_hold ? ld_addr : cpu_addr;
    assign mem_data_in = cpu_hold ? ld_data : 16'h0000;
    assign mem_enable  = cpu_hold ? ld_wr : cpu_en;
    assign mem_wr      = cpu_hold & ld_wr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            xacc         <= 8'h00;
            hi           <= 8'h00;
            cnt          <= 16'h0000;
            waddr        <= BASE_ADDR;
            ld_addr      <= BASE_ADDR;
            ld_data      <= 16'h0000;
            ld_wr        <= 1'b0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= 16'h0000;
        end else begin
            ld_wr <= 1'b0;
            if (reload) begin
                state        <= S_IDLE;
                cpu_hold     <= 1'b1;
                load_done    <= 1'b0;
                load_err     <= 1'b0;
                words_loaded <= 16'h0000;
            end else begin
                if (state == S_IDLE) begin
                    xacc         <= 8'h00;
                    words_loaded <= 16'h0000;
                end
                if (rx_valid) begin
                    case (state)
                        S_IDLE: state <= (rx_data == SYNC_BYTE) ? S_LEN_HI : S_IDLE;
                        S_LEN_HI: begin
                            hi    <= rx_data;
                            xacc  <= xacc ^ rx_data;
                            state <= S_LEN_LO;
                        end
                        S_LEN_LO: begin
                            xacc  <= xacc ^ rx_data;
                            cnt   <= len;
                            waddr <= BASE_ADDR;
                            state <= (len > DEPTH) ? S_ERR : (len == 16'h0000) ? S_CHK : S_DATA_HI;
                            load_err <= (len > DEPTH);
                        end
                        S_DATA_HI: begin
                            hi    <= rx_data;
                            xacc  <= xacc ^ rx_data;
                            state <= S_DATA_LO;
                        end
                        S_DATA_LO: begin
                            xacc         <= xacc ^ rx_data;
                            ld_wr        <= 1'b1;
                            ld_addr      <= waddr;
                            ld_data      <= {hi, rx_data};
                            waddr        <= waddr + 16'd1;
                            words_loaded <= words_loaded + 16'd1;
                            cnt          <= cnt - 16'd1;
                            state        <= (cnt == 16'd1) ? S_CHK : S_DATA_HI;
                        end
                        S_CHK: begin
                            state     <= ((xacc ^ rx_data) == 8'h00) ? S_DONE : S_ERR;
                            load_done <= ((xacc ^ rx_data) == 8'h00);
                            cpu_hold  <= ((xacc ^ rx_data) != 8'h00);
                            load_err  <= ((xacc ^ rx_data) != 8'h00);
                        end
                        S_ERR: begin
                            if (rx_data == SYNC_BYTE) begin
                                state        <= S_LEN_HI;
                                load_err     <= 1'b0;
                                xacc         <= 8'h00;
                                words_loaded <= 16'h0000;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_program_load_ctrl.sv
// tb_program_load_ctrl: directed frames with a write scoreboard and status checks
module tb_program_load_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_en = 1'b0;
    logic [15:0] mem_addr, mem_data_in, words_loaded;
    logic        mem_enable, mem_wr, cpu_hold, load_done, load_err;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [15:0] tbmem[0:1023];

    program_load_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .reload(reload),
        .cpu_addr(cpu_addr), .cpu_en(cpu_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_enable && mem_wr) tbmem[mem_addr[9:0]] <= mem_data_in;

    // monitor: every loader write must match the next expected {addr,data}
    always @(negedge clk) begin
        if (!rst && cpu_hold && (mem_wr || mem_enable)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%h data=%h en=%b wr=%b, expected none", mem_addr, mem_data_in, mem_enable, mem_wr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_data_in} !== e || !mem_wr || !mem_enable) begin
                    fails++;
                    $display("FAIL write got addr=%h data=%h en=%b wr=%b, expected addr=%h data=%h", mem_addr, mem_data_in, mem_enable, mem_wr, e[31:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
        send(d[15:8]);
        send(d[7:0]);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
    endtask

    task automatic good_frame();
        send(8'hA5); send(8'h00); send(8'h02);
        send_word(16'd0, 16'h1234);
        send_word(16'd1, 16'hABCD);
        send(8'h42);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_cpu_hold", {31'b0, cpu_hold}, 1);
        chk("rst_load_done", {31'b0, load_done}, 0);
        chk("rst_load_err", {31'b0, load_err}, 0);
        chk("rst_words", {16'b0, words_loaded}, 0);
        chk("rst_port", {mem_addr, mem_data_in}, 0);
        chk("rst_en_wr", {30'b0, mem_enable, mem_wr}, 0);

        good_frame();
        chk("good_done", {31'b0, load_done}, 1);
        chk("good_hold", {31'b0, cpu_hold}, 0);
        chk("good_words", {16'b0, words_loaded}, 2);
        cpu_addr = 16'd1; cpu_en = 1'b1; #1;
        chk("cpu_mux_addr", {16'b0, mem_addr}, 1);
        chk("cpu_mux_en_wr", {30'b0, mem_enable, mem_wr}, 2'b10);
        chk("cpu_mux_data", {16'b0, mem_data_in}, 0);
        chk("cpu_read", {16'b0, tbmem[mem_addr[9:0]]}, 16'hABCD);
        cpu_en = 1'b0; cpu_addr = 16'h0000;
        send(8'hA5);
        chk("done_ignores", {30'b0, load_done, cpu_hold}, 2'b10);

        pulse_reload();
        chk("reload_state", {29'b0, cpu_hold, load_done, load_err}, 3'b100);
        send(8'hA5); send(8'h00); send(8'h02);
        send_word(16'd0, 16'h1234);
        send_word(16'd1, 16'hABCD);
        send(8'hBD);
        chk("bad_chk_err", {29'b0, cpu_hold, load_done, load_err}, 3'b101);
        send(8'hA5);
        chk("err_restart_clear", {31'b0, load_err}, 0);
        send(8'h00); send(8'h02);
        send_word(16'd0, 16'h1234);
        send_word(16'd1, 16'hABCD);
        send(8'h42);
        chk("restart_done", {29'b0, cpu_hold, load_done, load_err}, 3'b010);

        pulse_reload();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        chk("n0_done", {29'b0, cpu_hold, load_done, load_err}, 3'b010);
        chk("n0_words", {16'b0, words_loaded}, 0);

        pulse_reload();
        send(8'h00); send(8'h13); send(8'h04);
        send(8'hA5); send(8'h04); send(8'h01);
        chk("oversize_err", {29'b0, cpu_hold, load_done, load_err}, 3'b101);
        chk("oversize_words", {16'b0, words_loaded}, 0);

        pulse_reload();
        send(8'hA5); send(8'h00); send(8'h02);
        send_word(16'd0, 16'h1234);
        @(posedge clk); #1;
        pulse_reload();
        chk("reload_mid_hold", {29'b0, cpu_hold, load_done, load_err}, 3'b100);
        @(posedge clk); #1;
        chk("reload_mid_words", {16'b0, words_loaded}, 0);
        good_frame();
        chk("after_reload_done", {29'b0, cpu_hold, load_done, load_err}, 3'b010);

        pulse_reload();
        send(8'hA5); send(8'h00); send(8'h04);
        send_word(16'd0, 16'h0102);
        send_word(16'd1, 16'h0304);
        send_word(16'd2, 16'h0506);
        send_word(16'd3, 16'h0708);
        send(8'h0C);
        chk("b2b_done", {29'b0, cpu_hold, load_done, load_err}, 3'b010);
        chk("b2b_words", {16'b0, words_loaded}, 4);
        chk("b2b_mem3", {16'b0, tbmem[3]}, 16'h0708);

        pulse_reload();
        send(8'hA5); send(8'h00); send(8'h04);
        send_word(16'd0, 16'h0102);
        send(8'h03);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_status", {28'b0, cpu_hold, load_done, load_err, mem_wr}, 4'b1000);
        chk("rst_mid_port", {mem_addr, mem_data_in}, 0);
        chk("rst_mid_words", {16'b0, words_loaded}, 0);
        #4 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
